uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_defs.sv | 13 +
 rtl/baud_gen.sv | 27 ++
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART framing definitions: state encoding and frame constants,
// kept separate so a transmitter can reuse them.
package uart_defs;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/baud_gen.sv
// Free-running 16x oversampling tick generator: one-clk pulse every DIV clocks.
module baud_gen
  import uart_defs::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19_200
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_q <= '0;
    else if (cnt_q == TOP) cnt_q <= '0;
    else                  cnt_q <= cnt_q + CW'(1);
  end

  // With DIV = 1 the counter sits at 0 and the tick is permanently high.
  assign tick = (cnt_q == TOP);
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and
// start-bit glitch rejection.
module uart_rx
  import uart_defs::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [3:0] SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic        tick;
  logic [1:0]  sync_q;
  logic        rx_s;
  uart_state_e state_q;
  logic [3:0]  samp_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic [7:0]  rx_data_q;
  logic        done_q, ferr_q, busy_q;

  baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      samp_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        // No tick qualification here so a start edge right after STOP is caught.
        IDLE: if (!rx_s) begin
          state_q <= START;
          samp_q  <= '0;
          busy_q  <= 1'b1;
        end
        START: if (tick) begin
          if (samp_q == SAMP_MID) begin
            samp_q <= '0;
            bit_q  <= '0;
            if (!rx_s) state_q <= DATA;
            else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            samp_q <= samp_q + 4'd1;
          end
        end
        DATA: if (tick) begin
          samp_q <= samp_q + 4'd1;
          if (samp_q == SAMP_LAST) begin
            shreg_q <= {rx_s, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == BIT_LAST) state_q <= STOP;
          end
        end
        STOP: if (tick) begin
          samp_q <= samp_q + 4'd1;
          if (samp_q == SAMP_LAST) begin
            if (rx_s) begin
              rx_data_q <= shreg_q;
              done_q    <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 64 clk per bit (DIV = 4).
module tb_uart_rx;
  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLK  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         done_cnt = 0, ferr_cnt = 0, viol = 0, done_cyc = 0;
  logic [7:0] log_q [64];
  logic       prev_strobe = 1'b0;
  logic       buf_clr = 1'b0;
  logic [7:0] bbuf [6];
  int         wp = 0;
  logic       full = 1'b0;
  int         n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor plus a 6-byte downstream buffer written by rx_done.
  always @(negedge clk) begin
    if (rx_done) begin
      log_q[done_cnt % 64] = rx_data;
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (rx_done && frame_err) viol++;
    if ((rx_done || frame_err) && prev_strobe) viol++;
    prev_strobe = rx_done || frame_err;
    if (buf_clr) wp = 0;
    else if (rx_done && wp < 6) begin
      bbuf[wp] = rx_data;
      wp++;
    end
    full = (wp == 6);
  end

  // Called at a negedge; returns at the negedge that ends the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit good_stop, output int s);
    s  = cyc;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = good_stop;
    if (good_stop) repeat (BIT_CLK) @(negedge clk);
    else begin
      // Low long enough to cover the mid-stop sample, then release.
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single;
    int base, fb, s, lat;
    base = done_cnt; fb = ferr_cnt;
    send_frame(8'hA5, 1'b1, s);
    repeat (64) @(negedge clk);
    lat = done_cyc - s;
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", done_cnt - base); end
    n_cmp++; if (log_q[base % 64] !== 8'hA5) begin n_bad++; $display("FAIL single_strobe_data: got %h want a5", log_q[base % 64]); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_hold: got %h want a5", rx_data); end
    n_cmp++; if (lat < 600 || lat > 616) begin n_bad++; $display("FAIL single_latency: got %0d want 600..616 clk", lat); end
    n_cmp++; if (ferr_cnt !== fb) begin n_bad++; $display("FAIL single_ferr: got %0d want %0d", ferr_cnt, fb); end
  endtask

  task automatic test_reset_midframe;
    int base, fb, s;
    base = done_cnt; fb = ferr_cnt;
    rx = 1'b0; repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1; repeat (BIT_CLK) @(negedge clk);
    rx = 1'b0; repeat (BIT_CLK) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0; rx = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    n_cmp++; if (done_cnt !== base || ferr_cnt !== fb) begin n_bad++; $display("FAIL mid_no_strobe: got %0d/%0d want 0/0", done_cnt - base, ferr_cnt - fb); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle_busy: got %b want 0", busy); end
    send_frame(8'h3C, 1'b1, s);
    repeat (64) @(negedge clk);
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL mid_recover_count: got %0d want 1", done_cnt - base); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL mid_recover_data: got %h want 3c", rx_data); end
  endtask

  task automatic test_frame_err;
    int base, fb, s;
    base = done_cnt; fb = ferr_cnt;
    send_frame(8'h81, 1'b0, s);
    repeat (128) @(negedge clk);
    n_cmp++; if (ferr_cnt - fb !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - fb); end
    n_cmp++; if (done_cnt !== base) begin n_bad++; $display("FAIL ferr_no_done: got %0d want 0", done_cnt - base); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL ferr_rx_data_kept: got %h want 3c", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int base, fb, hi;
    base = done_cnt; fb = ferr_cnt; hi = 0;
    rx = 1'b0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); hi += int'(busy); end
    rx = 1'b1;
    for (int i = 0; i < 64; i++) begin @(negedge clk); hi += int'(busy); end
    n_cmp++; if (hi < 20 || hi > 40) begin n_bad++; $display("FAIL glitch_busy_window: got %0d want 20..40 clk", hi); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    repeat (700) @(negedge clk);
    n_cmp++; if (done_cnt !== base || ferr_cnt !== fb) begin n_bad++; $display("FAIL glitch_no_strobe: got %0d/%0d want 0/0", done_cnt - base, ferr_cnt - fb); end
  endtask

  task automatic test_back_to_back;
    int base, fb, s;
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h00; exp_v[1] = 8'hFF; exp_v[2] = 8'h55;
    base = done_cnt; fb = ferr_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp_v[i], 1'b1, s);
    repeat (64) @(negedge clk);
    n_cmp++; if (done_cnt - base !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", done_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (log_q[(base + i) % 64] !== exp_v[i]) begin
        n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, log_q[(base + i) % 64], exp_v[i]);
      end
    end
    n_cmp++; if (ferr_cnt !== fb) begin n_bad++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - fb); end
  endtask

  task automatic test_buffer;
    int s;
    logic [7:0] d;
    buf_clr = 1'b1;
    repeat (2) @(negedge clk);
    buf_clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin d = 8'(i); send_frame(d, 1'b1, s); end
    repeat (64) @(negedge clk);
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL buf_not_full_at5: got %b want 0", full); end
    d = 8'h06; send_frame(d, 1'b1, s);
    repeat (64) @(negedge clk);
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL buf_full_at6: got %b want 1", full); end
    for (int i = 0; i < 6; i++) begin
      d = 8'(i + 1);
      n_cmp++;
      if (bbuf[i] !== d) begin n_bad++; $display("FAIL buf_entry%0d: got %h want %h", i, bbuf[i], d); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midframe();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_buffer();
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d violations want 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
